// File: rtl/cpu_pkg.sv
// Shared CPU constants and the multiply control state encoding.
package cpu_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 64;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_CALC = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mul_int.sv
// Combinational unsigned 32x32 multiplier used by the EX-stage multiply unit.
// It is timed as a multicycle path, so the operands must be held stable.
module mul_int
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0]  a,
  input  logic [WORD_W-1:0]  b,
  output logic [DWORD_W-1:0] p
);

  assign p = DWORD_W'(a) * DWORD_W'(b);

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Sequencer around mul_int. It latches the operand magnitudes, waits out the
// settling window, then writes the sign-corrected product into HI/LO.
module mul_hilo_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [WORD_W-1:0] hi_wdata,
  input  logic [WORD_W-1:0] lo_wdata,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(LATENCY);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  mag_a_q, mag_b_q;
  logic               neg_q;
  logic               done_q;
  logic [WORD_W-1:0]  hi_q, lo_q;
  logic               accept, finish;
  logic [DWORD_W-1:0] prod;
  logic [DWORD_W-1:0] result;

  mul_int u_mul_int (
    .a (mag_a_q),
    .b (mag_b_q),
    .p (prod)
  );

  // Negation wraps modulo 2^64, so a zero product stays zero.
  assign result = neg_q ? (~prod + DWORD_W'(1)) : prod;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = MUL_CALC;
        end
      end
      MUL_CALC: begin
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = MUL_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        // Two's-complement negate of 0x80000000 is itself, which is the
        // correct unsigned magnitude.
        mag_a_q <= (is_signed && op_a[WORD_W-1]) ? (~op_a + WORD_W'(1)) : op_a;
        mag_b_q <= (is_signed && op_b[WORD_W-1]) ? (~op_b + WORD_W'(1)) : op_b;
        neg_q   <= is_signed & (op_a[WORD_W-1] ^ op_b[WORD_W-1]);
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if (state_q == MUL_CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (finish) begin
        {hi_q, lo_q} <= result;
      end else if (state_q == MUL_IDLE) begin
        if (mthi) hi_q <= hi_wdata;
        if (mtlo) lo_q <= lo_wdata;
      end
    end
  end

  assign busy = (state_q == MUL_CALC);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a queue of expected {HI,LO} products.
module tb_mul_hilo_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, mthi, mtlo;
  logic [31:0] op_a, op_b, hi_wdata, lo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mul_hilo_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Caller is positioned at a negedge; drives one start edge and queues the model result.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    exp_q.push_back(model(sgn, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen (or after a bounded timeout).
  task automatic wait_done(output int busy_cycles, output bit seen, output bit overlap);
    busy_cycles = 0; seen = 1'b0; overlap = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done && busy) overlap = 1'b1;
      if (done) begin seen = 1'b1; break; end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic check_product(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got %h_%h", name, hi, lo);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({hi, lo} !== e) begin
      n_err++;
      $display("FAIL %s: got %h_%h expected %h_%h", name, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; is_signed = 0; mthi = 0; mtlo = 0;
    op_a = '0; op_b = '0; hi_wdata = '0; lo_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_multu_max();
    int bc; bit seen, ov;
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, seen, ov);
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL multu_max_done: no done pulse within bound"); end
    n_cmp++;
    if (bc !== int'(LAT - 1)) begin n_err++; $display("FAIL multu_max_busy: busy cycles %0d expected %0d", bc, LAT - 1); end
    n_cmp++;
    if (ov) begin n_err++; $display("FAIL multu_max_overlap: done seen with busy=1"); end
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_err++; $display("FAIL multu_max_const: got %h_%h expected fffffffe_00000001", hi, lo);
    end
    check_product("multu_max");
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_width: done=%b expected 0 one cycle later", done); end
  endtask

  task automatic test_signed();
    int bc; bit seen, ov;
    logic        sg[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ta[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFB, 32'h0000_0007, 32'h8000_0000};
    logic [31:0] tb_[6] = '{32'h0000_0003, 32'h0000_0003, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [63:0] k[6]   = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA, 64'h4000_0000_0000_0000,
                            64'h0, 64'hFFFF_FFFF_FFFF_FFCF, 64'h4000_0000_0000_0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_op(sg[i], ta[i], tb_[i]);
      wait_done(bc, seen, ov);
      n_cmp++;
      if (!seen || ov) begin n_err++; $display("FAIL signed_handshake[%0d]: seen=%b overlap=%b expected 1/0", i, seen, ov); end
      n_cmp++;
      if ({hi, lo} !== k[i]) begin n_err++; $display("FAIL signed_const[%0d]: got %h_%h expected %h", i, hi, lo, k[i]); end
      check_product("signed_model");
    end
  endtask

  task automatic test_mt();
    @(negedge clk);
    mthi = 1; mtlo = 1; hi_wdata = 32'h1234; lo_wdata = 32'h5678;
    @(posedge clk); #1;
    mthi = 0; mtlo = 0;
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      n_err++; $display("FAIL mt_both: got %h/%h expected 00001234/00005678", hi, lo);
    end
    mthi = 1; hi_wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    mthi = 0;
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'hCAFE_0001 || lo !== 32'h5678) begin
      n_err++; $display("FAIL mt_hi_only: got %h/%h expected cafe0001/00005678", hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    int bc; bit seen, ov;
    @(negedge clk);
    start_op(1'b0, 32'h0000_1000, 32'h0000_0003);
    @(negedge clk);
    start = 1; is_signed = 1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    mthi = 1; mtlo = 1; hi_wdata = 32'hAAAA_AAAA; lo_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    start = 0; mthi = 0; mtlo = 0;
    wait_done(bc, seen, ov);
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL busy_ignore_done: no done pulse within bound"); end
    check_product("busy_ignore");
    repeat (LAT + 1) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL busy_no_queue: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_start_with_mt();
    int bc; bit seen, ov;
    @(negedge clk);
    mthi = 1; hi_wdata = 32'h7777_7777;
    start_op(1'b0, 32'h0000_0005, 32'h0000_0006);
    mthi = 0;
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'h7777_7777) begin n_err++; $display("FAIL start_mt_write: hi=%h expected 77777777", hi); end
    wait_done(bc, seen, ov);
    check_product("start_mt_overwrite");
  endtask

  task automatic test_abort();
    bit bad_done = 0, bad_val = 0;
    @(negedge clk);
    start_op(1'b0, 32'd7, 32'd9);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_err++; $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) bad_done = 1;
      if (hi !== 32'h0 || lo !== 32'h0) bad_val = 1;
    end
    n_cmp++;
    if (bad_done || bad_val) begin
      n_err++; $display("FAIL abort_quiet: done_seen=%b hilo_changed=%b expected 0/0", bad_done, bad_val);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit seen, ov;
    @(negedge clk);
    start_op(1'b1, 32'h0001_0000, 32'hFFFF_0000);
    wait_done(bc, seen, ov);
    check_product("b2b_first");
    start_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(bc, seen, ov);
    n_cmp++;
    if (!seen || bc !== int'(LAT - 1)) begin
      n_err++; $display("FAIL b2b_latency: seen=%b busy cycles %0d expected 1/%0d", seen, bc, LAT - 1);
    end
    check_product("b2b_second");
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_mt();
    test_busy_ignore();
    test_start_with_mt();
    test_back_to_back();
    test_abort();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
